// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, MixColumns coefficients and the
// state encoding used by the iterative column engine.
package aes_pkg;

    localparam logic [7:0] POLY = 8'h1B;

    // Element 0 is the most significant slice, matching FIPS-197 byte order.
    typedef logic [0:3][7:0]  column_t;
    typedef logic [0:3][31:0] state_t;

    localparam column_t FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam column_t INV_COEF = {8'h0E, 8'h0B, 8'h0D, 8'h09};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
    endfunction

    // Only ever called with a constant c, so this folds into an xtime/XOR net.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = b;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc ^= p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [1:0] col_idx(input logic [1:0] base, input int offset);
        return base + 2'(offset);
    endfunction

    function automatic logic [1:0] row_idx(input int row, input int shift);
        return 2'(row + shift);
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational forward/inverse MixColumns for a single 32-bit column.
module mix_column_unit
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inverse,
    output logic [31:0] col_out
);

    column_t a;
    column_t fwd_r;
    column_t inv_r;

    assign a = col_in;

    // Both transforms use fixed coefficients; muxing the results rather than
    // the coefficients keeps every product a constant multiply.
    // NOTE: every always_comb output gets a default before the loops so no latch is inferred.
    always_comb begin
        fwd_r = '0;
        inv_r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                fwd_r[i] ^= gf_mul_const(a[row_idx(i, j)], FWD_COEF[j]);
                inv_r[i] ^= gf_mul_const(a[row_idx(i, j)], INV_COEF[j]);
            end
        end
    end

    assign col_out = inverse ? inv_r : fwd_r;

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns engine: COLS_PER_CYCLE columns per cycle, with
// valid/ready handshakes on both sides and one block in flight.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // For 4 columns per cycle the step wraps to 0, so cnt simply stays at 0.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    fsm_state_t  state;
    fsm_state_t  state_nxt;
    logic [1:0]  cnt;
    logic        mode;
    state_t      work;
    logic [31:0] col_res [COLS_PER_CYCLE];

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
            mix_column_unit u_col (
                .col_in  (work[col_idx(cnt, g)]),
                .inverse (mode),
                .col_out (col_res[g])
            );
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)        state_nxt = BUSY;
            BUSY:    if (cnt == LAST_CNT) state_nxt = DONE;
            DONE:    if (out_ready)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Outputs decode the registered state only; no input reaches them combinationally.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        state_out = (state == DONE) ? work : '0;
    end

    // NOTE: the working register is reset too, so an aborted block leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            work <= '0;
            mode <= 1'b0;
            cnt  <= '0;
        end else if (state == IDLE && in_valid) begin
            work <= state_in;
            mode <= inverse;
            cnt  <= '0;
        end else if (state == BUSY) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                work[col_idx(cnt, g)] <= col_res[g];
            end
            cnt <= cnt + CNT_STEP;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4 in parallel.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         inverse;
    logic         out_ready;
    logic [127:0] state_in;
    logic         in_ready_v  [3];
    logic         out_valid_v [3];
    logic [127:0] state_out_v [3];

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < 3; k++) begin : g_dut
            mix_columns_seq #(.COLS_PER_CYCLE(1 << k)) dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready_v[k]),
                .state_in  (state_in),
                .inverse   (inverse),
                .out_valid (out_valid_v[k]),
                .out_ready (out_ready),
                .state_out (state_out_v[k])
            );
        end
    endgenerate

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: direct xtime form for forward; inverse as a
    // pre-conditioning step followed by the forward transform.
    function automatic logic [7:0] m2(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   a [4];
        logic [7:0]   u, v;
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
            if (inv) begin
                u = m2(m2(a[0] ^ a[2]));
                v = m2(m2(a[1] ^ a[3]));
                a[0] ^= u; a[1] ^= v; a[2] ^= u; a[3] ^= v;
            end
            for (int i = 0; i < 4; i++)
                r[127 - 32*c - 8*i -: 8] = m2(a[i]) ^ m2(a[(i+1)%4]) ^ a[(i+1)%4]
                                         ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
        return r;
    endfunction

    typedef struct {
        logic [127:0] exp;
        int           acc;
    } sb_t;

    sb_t  sbq [3][$];
    logic prev_valid [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin : mon
        sb_t e;
        for (int k = 0; k < 3; k++) begin
            if (out_valid_v[k] === 1'b1 && !prev_valid[k] && sbq[k].size() > 0)
                check($sformatf("latency cpc%0d", 1 << k), cyc - sbq[k][0].acc, 4 >> k);
            if (out_valid_v[k] === 1'b1 && out_ready) begin
                if (sbq[k].size() == 0) begin
                    check($sformatf("unexpected out_valid cpc%0d", 1 << k), out_valid_v[k], 1'b0);
                end else begin
                    e = sbq[k].pop_front();
                    check($sformatf("state_out cpc%0d", 1 << k), state_out_v[k], e.exp);
                end
            end
            prev_valid[k] = (out_valid_v[k] === 1'b1);
        end
    end

    function automatic logic [2:0] all_ready();
        return {in_ready_v[0], in_ready_v[1], in_ready_v[2]};
    endfunction

    function automatic logic [2:0] all_valid();
        return {out_valid_v[0], out_valid_v[1], out_valid_v[2]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (all_ready() != 3'b111 && n < 50) begin
            tick();
            n++;
        end
        check("in_ready before send", all_ready(), 3'b111);
    endtask

    // Offers one block, then scrambles state_in/inverse to show they are ignored after acceptance.
    task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] exp);
        wait_ready();
        in_valid = 1'b1;
        state_in = s;
        inverse  = inv;
        tick();
        for (int k = 0; k < 3; k++) sbq[k].push_back('{exp, cyc});
        in_valid = 1'b0;
        state_in = rnd128();
        inverse  = ~inv;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 100) begin
            tick();
            n++;
        end
        check("scoreboard drained", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
        for (int k = 0; k < 3; k++) sbq[k].delete();
    endtask

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [127:0] x;
        logic [127:0] y;

        vecs[0] = '{128'hdb135345f20a225cc6c6c6c6d4d4d4d5, 1'b0, 128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6};
        vecs[1] = '{128'h01010101c6c6c6c6d4d4d4d5db135345, 1'b0, 128'h01010101c6c6c6c6d5d5d7d68e4da1bc};
        vecs[2] = '{FIPS_IN, 1'b0, FIPS_OUT};
        vecs[3] = '{FIPS_OUT, 1'b1, FIPS_IN};
        vecs[4] = '{128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6, 1'b1, 128'hdb135345f20a225cc6c6c6c6d4d4d4d5};
        vecs[5] = '{128'h0, 1'b0, 128'h0};
        vecs[6] = '{128'hf20a225c01010101db135345c6c6c6c6, 1'b0, 128'h9fdc589d010101018e4da1bcc6c6c6c6};

        rst       = 1'b1;
        in_valid  = 1'b0;
        inverse   = 1'b0;
        out_ready = 1'b1;
        state_in  = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", all_ready(), 3'b111);
        check("reset out_valid", all_valid(), 3'b000);
        for (int k = 0; k < 3; k++) check($sformatf("reset state_out cpc%0d", 1 << k), state_out_v[k], '0);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].din, vecs[i].inv, vecs[i].exp);
            drain();
        end

        for (int i = 0; i < 4; i++) begin
            x = rnd128();
            y = model(x, 1'b0);
            send(x, 1'b0, y);
            send(y, 1'b1, x);
            drain();
        end

        // Backpressure: output held, a second block waits, then is taken right after the handshake.
        out_ready = 1'b0;
        send(FIPS_IN, 1'b0, FIPS_OUT);
        in_valid = 1'b1;
        state_in = FIPS_OUT;
        inverse  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("in_ready low under backpressure", all_ready(), 3'b000);
            if (i >= 4) begin
                check("out_valid held", all_valid(), 3'b111);
                for (int k = 0; k < 3; k++)
                    check($sformatf("state_out held cpc%0d", 1 << k), state_out_v[k], FIPS_OUT);
            end
        end
        out_ready = 1'b1;
        tick();
        check("in_ready after output handshake", all_ready(), 3'b111);
        check("out_valid after output handshake", all_valid(), 3'b000);
        tick();
        for (int k = 0; k < 3; k++) sbq[k].push_back('{FIPS_IN, cyc});
        in_valid = 1'b0;
        inverse  = 1'b0;
        state_in = rnd128();
        check("second block accepted", all_ready(), 3'b000);
        drain();

        // Reset while the one-column engine is in BUSY with cnt=2.
        out_ready = 1'b0;
        send(FIPS_IN, 1'b0, FIPS_OUT);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid reset out_valid", all_valid(), 3'b000);
        check("mid reset in_ready", all_ready(), 3'b111);
        for (int k = 0; k < 3; k++) check($sformatf("mid reset state_out cpc%0d", 1 << k), state_out_v[k], '0);
        for (int k = 0; k < 3; k++) sbq[k].delete();
        rst       = 1'b0;
        out_ready = 1'b1;
        send(FIPS_OUT, 1'b1, FIPS_IN);
        drain();

        // Reset coinciding with in_valid must not accept the block.
        wait_ready();
        rst      = 1'b1;
        in_valid = 1'b1;
        state_in = FIPS_IN;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("reset+in_valid not accepted", all_ready(), 3'b111);
        repeat (8) tick();
        check("no output without handshake", all_valid(), 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
